dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the hart's dmem port: the memory end of the `o_dmem_addr/ren/wen/wdata/mask` ↔ `i_dmem_rdata` interface. It replaces the combinational memory model with a realistic fixed-latency memory. The block adds a ready/valid response handshake and byte-masked storage. It sits between the hart's memory stage and a word-addressed storage array, and is the target for the stall-aware pipelined hart.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: storage size in 32-bit words; must be a power of 2.
- `LATENCY`, default 2: cycles from request acceptance to response; must be ≥1.

Ports:
- `i_clk` input, 1: the only clock.
- `i_rst` input, 1: reset, asynchronous and active-high.
- `i_dmem_addr` input, 32: byte address; must be word-aligned.
- `i_dmem_ren` input, 1: read request.
- `i_dmem_wen` input, 1: write request.
- `i_dmem_wdata` input, 32: write data, already lane-shifted.
- `i_dmem_mask` input, 4: byte-lane enables; bit n selects bits [8n+7:8n].
- `o_dmem_ready` input-side, output, 1: a request is accepted this cycle when ready=1 and (ren|wen)=1.
- `o_dmem_valid` output, 1: one-cycle response pulse.
- `o_dmem_err` output, 1: qualifies valid; the request was illegal.
- `o_dmem_rdata` output, 32: read data; registered.

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: ready=1. On accept, latch addr, ren, wen, wdata and mask. Load the counter with LATENCY-1. Go to WAIT if LATENCY>1, otherwise go to RESP.
  - WAIT: ready=0. Decrement the counter each cycle. When the counter reaches 1, go to RESP.
  - RESP: valid=1, ready=1. An accept in RESP starts a new request, behaving exactly as an accept in IDLE. With no accept, go to IDLE.
- Requests presented while ready=0 are ignored: no latch and no side effect. The hart must hold the request until it is accepted.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias.
- Illegal request: addr[1:0]≠0, or ren&wen both set.
  - Accepted normally.
  - Storage is untouched.
  - The response has err=1 and rdata is unchanged.
- Write: only the masked bytes are written; unmasked bytes are preserved. Response has err=0; rdata is unchanged.
- Read: masked bytes come from storage; unmasked lanes read 0. Response has err=0.
- Storage is not reset. Its contents are undefined at power-up and preserved across `i_rst`.

## Timing
- Reset values: state=IDLE, counter=0, ready=1, valid=0, err=0, rdata=0.
- For a request accepted in cycle C, valid and err are high in cycle C+LATENCY only.
- The storage write and the rdata capture both happen on the clock edge ending cycle C+LATENCY-1.
  - A read accepted in cycle C+LATENCY therefore sees the write.
- ready is low in cycles C+1 … C+LATENCY-1 and high again in cycle C+LATENCY. Peak throughput is one request per LATENCY cycles.
- LATENCY=1: ready stays at 1 continuously and back-to-back requests are accepted every cycle.
- rdata holds its value until the next read response.
- Reset mid-operation:
  - The pending request is dropped; a pending write does not occur.
  - ready=1 immediately, asynchronously.
  - No valid pulse is produced for the aborted request.

## Structure
- Shared constants go in `dmem_pkg`: state encodings, the full mask `4'b1111`, and the illegal-request predicate.
- Sub-module `dmem_array`: single-port, `DEPTH_WORDS`×32 storage with a per-byte write enable and registered read. It has no reset.
- `dmem_responder` holds the FSM, counter, request latch, error detection, masking of read lanes and the output registers.

## Test plan
All scenarios use LATENCY=2 and DEPTH_WORDS=1024.
1. Write 0xDEADBEEF to 0x010 with mask 1111, then read 0x010 with mask 1111 → each response arrives 2 cycles after acceptance; rdata=0xDEADBEEF, err=0.
2. Write 0xAA000000 to 0x010 with mask 1000, then read with mask 1111 → rdata=0xAAADBEEF. A read with mask 0011 → rdata=0x0000BEEF.
3. Read 0x012, then issue ren&wen on 0x010 → both responses have err=1, rdata is unchanged, and a follow-up read of 0x010 returns 0xAAADBEEF.
4. Write 0x12345678 to 0x1010 → a read of 0x010 returns 0x12345678 (aliasing).
5. Accept a write of 0xFFFFFFFF to 0x010, then assert `i_rst` in cycle C+1 → ready=1 immediately and valid never pulses. A later read returns 0x12345678.
6. Present a new read in the RESP cycle of a write → it is accepted and its response arrives 2 cycles later. A request held during a ready=0 cycle is not double-accepted.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] MASK_FULL = 4'b1111;

  // One captured request as presented by the hart.
  typedef struct packed {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  // A request is illegal when it is misaligned or asks for read and write at once.
  function automatic logic is_illegal(input logic [1:0] addr_lo, input logic ren, input logic wen);
    return (addr_lo != 2'b00) || (ren && wen);
  endfunction

  // Expand 4 byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] mask);
    logic [31:0] m;
    m = '0;
    if (mask == MASK_FULL) begin
      m = '1;
    end else begin
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mask[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem request/response bundle between the hart (master) and the responder (slave).
interface dmem_responder_if;
  logic [31:0] i_dmem_addr;
  logic        i_dmem_ren;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic        o_dmem_ready;
  logic        o_dmem_valid;
  logic        o_dmem_err;
  logic [31:0] o_dmem_rdata;

  modport master (
    output i_dmem_addr, i_dmem_ren, i_dmem_wen, i_dmem_wdata, i_dmem_mask,
    input  o_dmem_ready, o_dmem_valid, o_dmem_err, o_dmem_rdata
  );

  modport slave (
    input  i_dmem_addr, i_dmem_ren, i_dmem_wen, i_dmem_wdata, i_dmem_mask,
    output o_dmem_ready, o_dmem_valid, o_dmem_err, o_dmem_rdata
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// Deliberately unreset: contents survive the responder's reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write; read word is captured only on a read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, waits LATENCY
// cycles, then pulses valid (with err for illegal requests).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef logic [CW-1:0] cnt_t;

  state_t      state, state_nxt;
  cnt_t        cnt;
  req_t        in_req, req_q, op_req;
  logic        accept;
  logic        err_q;
  logic        op_go, op_legal;
  logic        arr_we, arr_re;
  logic [3:0]  rd_mask_q;
  logic [31:0] arr_q;
  logic        unused_addr_bits;

  assign in_req = '{addr:  bus.i_dmem_addr,
                    ren:   bus.i_dmem_ren,
                    wen:   bus.i_dmem_wen,
                    wdata: bus.i_dmem_wdata,
                    mask:  bus.i_dmem_mask};

  assign accept = bus.o_dmem_ready && (bus.i_dmem_ren || bus.i_dmem_wen);

  // The storage access happens on the edge ending cycle C+LATENCY-1. With
  // LATENCY=1 that is the accept edge itself, so the live request is used.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign op_go  = accept && !i_rst;
      assign op_req = in_req;
    end else begin : g_latn
      assign op_go  = (state == S_WAIT) && (cnt == cnt_t'(1));
      assign op_req = req_q;
    end
  endgenerate

  assign op_legal = !is_illegal(op_req.addr[1:0], op_req.ren, op_req.wen);
  assign arr_we   = op_go && op_legal && op_req.wen;
  assign arr_re   = op_go && op_legal && op_req.ren;

  assign unused_addr_bits = ^op_req.addr[31:AW+2];

  // State register; async reset returns ready high immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: an accept in IDLE or RESP starts a request; WAIT runs down the counter.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == cnt_t'(1)) state_nxt = S_RESP;
      S_RESP: begin
        if (accept) state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
        else        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latency counter: loaded on accept, decremented while waiting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                cnt <= '0;
    else if (accept)          cnt <= cnt_t'(LATENCY - 1);
    else if (state == S_WAIT) cnt <= cnt - cnt_t'(1);
  end

  // Request latch; pure datapath, only meaningful while a request is in flight.
  always_ff @(posedge i_clk) begin
    if (accept) req_q <= in_req;
  end

  // Error flag for the response, decided at acceptance time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       err_q <= 1'b0;
    else if (accept) err_q <= is_illegal(in_req.addr[1:0], in_req.ren, in_req.wen);
  end

  // Lane mask of the last completed read; zero after reset so rdata reads 0
  // even though the unreset array output is unknown.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       rd_mask_q <= '0;
    else if (arr_re) rd_mask_q <= op_req.mask;
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (i_clk),
    .we    (arr_we),
    .be    (op_req.mask),
    .re    (arr_re),
    .idx   (op_req.addr[AW+1:2]),
    .wdata (op_req.wdata),
    .rdata (arr_q)
  );

  // Both operands are registers updated together on a read, so rdata holds
  // between reads and unmasked lanes read as zero.
  assign bus.o_dmem_rdata = arr_q & lane_mask(rd_mask_q);
  assign bus.o_dmem_ready = (state != S_WAIT);
  assign bus.o_dmem_valid = (state == S_RESP);
  assign bus.o_dmem_err   = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_dmem_responder;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] ref_rdata;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(L)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: what each request should answer, from the behavioural rules.
  function automatic void model(input logic [31:0] a, input logic r, input logic w,
                                input logic [31:0] d, input logic [3:0] m,
                                output logic e, output logic [31:0] rd);
    int idx;
    idx = int'(a[11:2]);
    if (a[1:0] != 2'b00 || (r && w)) begin
      e = 1'b1;
    end else begin
      e = 1'b0;
      if (w) begin
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else if (r) begin
        ref_rdata = 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) ref_rdata[8*b +: 8] = ref_mem[idx][8*b +: 8];
      end
    end
    rd = ref_rdata;
  endfunction

  // Present a request until accepted, then wait for the response (bounded).
  task automatic txn(input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] d, input logic [3:0] m,
                     output logic e, output logic [31:0] rd, output int lat);
    int wt;
    @(negedge clk);
    bus.i_dmem_addr = a; bus.i_dmem_ren = r; bus.i_dmem_wen = w;
    bus.i_dmem_wdata = d; bus.i_dmem_mask = m;
    wt = 0;
    while (bus.o_dmem_ready !== 1'b1 && wt < 20) begin @(negedge clk); wt++; end
    @(negedge clk);
    bus.i_dmem_ren = 1'b0; bus.i_dmem_wen = 1'b0;
    lat = 1;
    while (bus.o_dmem_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    e  = bus.o_dmem_err;
    rd = bus.o_dmem_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_dmem_addr = '0; bus.i_dmem_ren = 1'b0; bus.i_dmem_wen = 1'b0;
    bus.i_dmem_wdata = '0; bus.i_dmem_mask = '0;
    ref_rdata = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_dmem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.o_dmem_ready); end
    n_checks++; if (bus.o_dmem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.o_dmem_valid); end
    n_checks++; if (bus.o_dmem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.o_dmem_err); end
    n_checks++; if (bus.o_dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.o_dmem_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic e, ee; logic [31:0] rd, er; int lat;
    model(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, ee, er);
    txn(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, e, rd, lat);
    n_checks++; if (lat !== L) begin n_fail++; $display("FAIL basic_wr_lat got=%0d exp=%0d", lat, L); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err got=%b exp=0", e); end
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, e, rd, lat);
    n_checks++; if (lat !== L) begin n_fail++; $display("FAIL basic_rd_lat got=%0d exp=%0d", lat, L); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_rd_err got=%b exp=0", e); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_mask();
    logic e, ee; logic [31:0] rd, er; int lat;
    model(32'h10, 1'b0, 1'b1, 32'hAA000000, 4'b1000, ee, er);
    txn(32'h10, 1'b0, 1'b1, 32'hAA000000, 4'b1000, e, rd, lat);
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, e, rd, lat);
    n_checks++; if (rd !== 32'hAAADBEEF) begin n_fail++; $display("FAIL mask_wr_byte3 got=%h exp=aaadbeef", rd); end
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'b0011, ee, er);
    txn(32'h10, 1'b1, 1'b0, 32'h0, 4'b0011, e, rd, lat);
    n_checks++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL mask_rd_lo got=%h exp=0000beef", rd); end
  endtask

  task automatic test_illegal();
    logic e, ee; logic [31:0] rd, er; int lat;
    model(32'h12, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    txn(32'h12, 1'b1, 1'b0, 32'h0, 4'hF, e, rd, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_misalign_err got=%b exp=1", e); end
    n_checks++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL illegal_misalign_rdata got=%h exp=0000beef", rd); end
    model(32'h10, 1'b1, 1'b1, 32'h55555555, 4'hF, ee, er);
    txn(32'h10, 1'b1, 1'b1, 32'h55555555, 4'hF, e, rd, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_rw_err got=%b exp=1", e); end
    n_checks++; if (lat !== L) begin n_fail++; $display("FAIL illegal_rw_lat got=%0d exp=%0d", lat, L); end
    n_checks++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL illegal_rw_rdata got=%h exp=0000beef", rd); end
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, e, rd, lat);
    n_checks++; if (rd !== 32'hAAADBEEF) begin n_fail++; $display("FAIL illegal_no_write got=%h exp=aaadbeef", rd); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL illegal_followup_err got=%b exp=0", e); end
  endtask

  task automatic test_alias();
    logic e, ee; logic [31:0] rd, er; int lat;
    model(32'h1010, 1'b0, 1'b1, 32'h12345678, 4'hF, ee, er);
    txn(32'h1010, 1'b0, 1'b1, 32'h12345678, 4'hF, e, rd, lat);
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, e, rd, lat);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_rd got=%h exp=12345678", rd); end
  endtask

  task automatic test_reset_mid();
    logic e, ee; logic [31:0] rd, er; int lat; int pulses;
    @(negedge clk);
    bus.i_dmem_addr = 32'h10; bus.i_dmem_ren = 1'b0; bus.i_dmem_wen = 1'b1;
    bus.i_dmem_wdata = 32'hFFFFFFFF; bus.i_dmem_mask = 4'hF;
    @(negedge clk);
    bus.i_dmem_wen = 1'b0;
    n_checks++; if (bus.o_dmem_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.o_dmem_ready); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.o_dmem_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_async got=%b exp=1", bus.o_dmem_ready); end
    ref_rdata = 32'h0;
    pulses = 0;
    repeat (2) begin @(negedge clk); if (bus.o_dmem_valid === 1'b1) pulses++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.o_dmem_valid === 1'b1) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_no_valid got=%0d pulses exp=0", pulses); end
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, e, rd, lat);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_write_dropped got=%h exp=12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic ee; logic [31:0] er;
    model(32'h10, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, ee, er);
    @(negedge clk);
    n_checks++; if (bus.o_dmem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got=%b exp=1", bus.o_dmem_ready); end
    bus.i_dmem_addr = 32'h10; bus.i_dmem_ren = 1'b0; bus.i_dmem_wen = 1'b1;
    bus.i_dmem_wdata = 32'hCAFEF00D; bus.i_dmem_mask = 4'hF;
    @(negedge clk);
    bus.i_dmem_wen = 1'b0;
    n_checks++; if (bus.o_dmem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_wait_ready got=%b exp=0", bus.o_dmem_ready); end
    @(negedge clk);
    n_checks++; if (bus.o_dmem_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_valid got=%b exp=1", bus.o_dmem_valid); end
    n_checks++; if (bus.o_dmem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resp_ready got=%b exp=1", bus.o_dmem_ready); end
    model(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, ee, er);
    bus.i_dmem_ren = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.o_dmem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_busy got=%b exp=0", bus.o_dmem_ready); end
    n_checks++; if (bus.o_dmem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_early got=%b exp=0", bus.o_dmem_valid); end
    @(negedge clk);
    n_checks++; if (bus.o_dmem_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_valid got=%b exp=1", bus.o_dmem_valid); end
    n_checks++; if (bus.o_dmem_rdata !== er) begin n_fail++; $display("FAIL b2b_rd_data got=%h exp=%h", bus.o_dmem_rdata, er); end
    bus.i_dmem_ren = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.o_dmem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_double got=%b exp=0", bus.o_dmem_valid); end
    n_checks++; if (bus.o_dmem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_back_idle got=%b exp=1", bus.o_dmem_ready); end
  endtask

  task automatic test_random();
    logic e, ee; logic [31:0] rd, er, a, d; logic r, w; logic [3:0] m; int lat; int k;
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(4 * i); d = $urandom;
      model(a, 1'b0, 1'b1, d, 4'hF, ee, er);
      txn(a, 1'b0, 1'b1, d, 4'hF, e, rd, lat);
    end
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 7));
      a = 32'h200 + 32'(4 * k) + (32'($urandom_range(0, 3)) << 12);
      d = $urandom; m = 4'($urandom);
      r = 1'($urandom); w = !r;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin r = 1'b1; w = 1'b1; end
      model(a, r, w, d, m, ee, er);
      txn(a, r, w, d, m, e, rd, lat);
      n_checks++; if (lat !== L) begin n_fail++; $display("FAIL rand_lat[%0d] got=%0d exp=%0d", i, lat, L); end
      n_checks++; if (e !== ee) begin n_fail++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, e, ee); end
      n_checks++; if (rd !== er) begin n_fail++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rd, er); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_illegal();
    test_alias();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
